qspis_top: RTL and testbench
============================

QSPIS_TOP -- requirements
Module: qspis_top

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with no parameters:
- sys_clk  in  1  system clock; sclk frequency SHALL be at most sys_clk/8.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  QSPI clock, SPI mode 0, asynchronous to sys_clk.
- ssn  in  1  chip select, active low.
- sdin  in  4  quad data in, MSB nibble first.
- sdout  out  4  quad data out.
- sdout_oen  out  1  output enable, active low (0 = drive sdout).
- spi_if_st  out  3  current state encoding.
- sck_toggle  out  1  one-cycle pulse per detected sclk rising edge.
- bitcnt  out  6  bits transferred in the current phase.
- inst_trg  out  1  one-cycle pulse when the command byte is complete.
- addr_trg  out  1  one-cycle pulse when the address is complete.
- spi_st_trans  out  1  high while a transaction is active (synchronized ssn low).
- spi_trig  out  1  one-cycle pulse on synchronized ssn falling edge.
- wbm_cyc_o, wbm_stb_o  out  1  Wishbone request; cyc SHALL equal stb.
- wbm_adr_o  out  32  byte address.
- wbm_we_o  out  1  1 = write.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte enables; constant 4'hF.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  error; terminates the cycle like ack.

Function
REQ-002 sclk, ssn and sdin SHALL each pass a 2-flop synchronizer; rise and fall edges of sclk SHALL be detected from the synchronized value.
REQ-003 sdin SHALL be sampled on each detected rising edge, 4 bits per edge; bitcnt SHALL increment by 4 per edge and clear at each phase change.
REQ-004 States (spi_if_st): IDLE=0, CMD=1, ADDR=2, DUMMY=3, WDATA=4, RDATA=5, WAIT=6.
REQ-005 Transitions:
- IDLE->CMD on the ssn fall.
- CMD->ADDR after 8 bits.
- After 32 address bits: WDATA for command 0x02, DUMMY for command 0x0B, otherwise WAIT, which ignores sclk until ssn rises.
REQ-006 When the address completes, wbm_adr_o SHALL load it, with bits [1:0] forced to 0.
REQ-007 Write: each 32 received bits (big-endian, first nibble = bits 31:28) SHALL issue one WB write to the current address, then the address SHALL increment by 4.
REQ-008 Read: when the address completes, a WB read SHALL be issued. DUMMY SHALL last 4 sclk cycles. RDATA SHALL shift the word out MSB nibble first, changing sdout on detected sclk falling edges. The first nibble SHALL be driven on the falling edge that ends DUMMY.
REQ-009 Read prefetch: on loading a word into the shift register, the next WB read (address+4) SHALL be issued immediately.
REQ-010 sdout_oen SHALL be 0 only in RDATA and the last DUMMY half-cycle; otherwise 1, with sdout = 0.
REQ-011 WB handshake:
- stb/cyc SHALL assert for one request and hold adr/dat/we stable until ack or err.
- At most one outstanding cycle.
- Read data with err SHALL be replaced by 32'hFFFF_FFFF.
REQ-012 A ssn rise in any state SHALL return to IDLE; a pending WB cycle SHALL complete before a new one may start; partially received write words SHALL be discarded.
REQ-013 spi_trig, inst_trg, addr_trg and sck_toggle SHALL be single sys_clk pulses.

Reset
REQ-014 On rst_n low:
- All outputs 0 except sdout_oen=1 and wbm_sel_o=4'hF.
- State IDLE, synchronizers filled with ssn=1, sclk=0.

Structure
REQ-015 A shared package SHALL hold the state encodings, command codes (CMD_WR=8'h02, CMD_RD=8'h0B) and DUMMY_CYCLES=4.
REQ-016 One sub-module, qspis_sync, SHALL implement the synchronizers and edge detection; all other logic SHALL reside in qspis_top.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Write 0x02, addr 0x00000010, data 0x12345678 -> one WB write, adr=0x10, dat=0x12345678, sel=F, we=1; inst_trg and addr_trg pulse once each.
- Write burst of two words 0xA5A5A5A5, 0x5A5A5A5A at addr 0x20 -> WB writes at 0x20 and 0x24.
- Read 0x0B at addr 0x40, memory 0xDEADBEEF -> after 4 dummy cycles sdout nibbles are D,E,A,D,B,E,E,F; sdout_oen=0 during data; a prefetch read to 0x44 is issued.
- Read with wbm_err_i responding -> shifted word is 0xFFFFFFFF.
- Unknown command 0x55 -> no WB activity, spi_if_st=6 until ssn rises, then IDLE.
- ssn raised after 12 write-data bits -> no WB write, state IDLE, sdout_oen=1; rst_n low mid-transfer -> reset values within 0 cycles (asynchronous).

Source files
------------

// File: rtl/qspis_pkg.sv
// Shared types and constants for the quad-SPI slave to Wishbone bridge.
package qspis_pkg;

    localparam int unsigned NIB_W        = 4;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned BITCNT_W     = 6;
    localparam int unsigned DUMMY_CYCLES = 4;

    localparam logic [7:0] CMD_WR = 8'h02;
    localparam logic [7:0] CMD_RD = 8'h0B;

    localparam logic [BITCNT_W-1:0] NIB_STEP   = BITCNT_W'(NIB_W);
    localparam logic [BITCNT_W-1:0] CMD_LAST   = BITCNT_W'(8 - NIB_W);
    localparam logic [BITCNT_W-1:0] WORD_LAST  = BITCNT_W'(WORD_W - NIB_W);
    localparam logic [BITCNT_W-1:0] DUMMY_LAST = BITCNT_W'((DUMMY_CYCLES - 1) * NIB_W);
    localparam logic [BITCNT_W-1:0] DUMMY_END  = BITCNT_W'(DUMMY_CYCLES * NIB_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_WDATA = 3'd4,
        ST_RDATA = 3'd5,
        ST_WAIT  = 3'd6
    } spi_st_e;

    typedef struct packed {
        logic                we;
        logic [WORD_W-1:0]   adr;
        logic [WORD_W-1:0]   dat;
    } wb_req_t;

    // Wishbone addresses are word aligned
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/qspis_sync.sv
// Two-flop synchronizers for the QSPI pins plus registered sclk/ssn edge pulses.
module qspis_sync (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       sclk_i,
    input  logic       ssn_i,
    input  logic [3:0] sdin_i,
    output logic       sclk_rise_o,
    output logic       sclk_fall_o,
    output logic       ssn_fall_o,
    output logic       ssn_rise_o,
    output logic       ssn_act_o,
    output logic [3:0] sdin_o
);

    logic [1:0] sclk_sync_q;
    logic       sclk_prev_q;
    logic [1:0] ssn_sync_q;
    logic       ssn_prev_q;
    logic [3:0] sdin_meta_q;
    logic [3:0] sdin_sync_q;

    // sdin_o lags one cycle so it lines up with the registered edge pulses
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            ssn_sync_q  <= 2'b11;
            ssn_prev_q  <= 1'b1;
            sdin_meta_q <= 4'h0;
            sdin_sync_q <= 4'h0;
            sclk_rise_o <= 1'b0;
            sclk_fall_o <= 1'b0;
            ssn_fall_o  <= 1'b0;
            ssn_rise_o  <= 1'b0;
            ssn_act_o   <= 1'b0;
            sdin_o      <= 4'h0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk_i};
            sclk_prev_q <= sclk_sync_q[1];
            ssn_sync_q  <= {ssn_sync_q[0], ssn_i};
            ssn_prev_q  <= ssn_sync_q[1];
            sdin_meta_q <= sdin_i;
            sdin_sync_q <= sdin_meta_q;
            sclk_rise_o <= sclk_sync_q[1] & ~sclk_prev_q;
            sclk_fall_o <= ~sclk_sync_q[1] & sclk_prev_q;
            ssn_fall_o  <= ~ssn_sync_q[1] & ssn_prev_q;
            ssn_rise_o  <= ssn_sync_q[1] & ~ssn_prev_q;
            ssn_act_o   <= ~ssn_sync_q[1];
            sdin_o      <= sdin_sync_q;
        end
    end

endmodule

// File: rtl/qspis_top.sv
// Quad-SPI slave (mode 0) bridging command/address/data frames onto a Wishbone master.
module qspis_top
    import qspis_pkg::*;
(
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        ssn,
    input  logic [3:0]  sdin,
    output logic [3:0]  sdout,
    output logic        sdout_oen,
    output logic [2:0]  spi_if_st,
    output logic        sck_toggle,
    output logic [5:0]  bitcnt,
    output logic        inst_trg,
    output logic        addr_trg,
    output logic        spi_st_trans,
    output logic        spi_trig,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [31:0] wbm_adr_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    logic       sclk_rise;
    logic       sclk_fall;
    logic       ssn_fall;
    logic       ssn_rise;
    logic       ssn_act;
    logic [3:0] sdin_s;

    qspis_sync u_sync (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .sclk_i      (sclk),
        .ssn_i       (ssn),
        .sdin_i      (sdin),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .ssn_fall_o  (ssn_fall),
        .ssn_rise_o  (ssn_rise),
        .ssn_act_o   (ssn_act),
        .sdin_o      (sdin_s)
    );

    spi_st_e             state_q;
    logic [BITCNT_W-1:0] bitcnt_q;
    logic [27:0]         rx_q;
    logic [7:0]          cmd_q;
    logic [WORD_W-1:0]   addr_q;
    logic [27:0]         tx_q;
    logic [2:0]          nib_q;
    logic [WORD_W-1:0]   rbuf_q;
    wb_req_t             req_q;
    logic                req_vld_q;
    logic [3:0]          sdout_q;
    logic                sdout_oen_q;
    logic                inst_trg_q;
    logic                addr_trg_q;
    logic                wbm_cyc_q;
    logic [WORD_W-1:0]   wbm_adr_q;
    logic                wbm_we_q;
    logic [WORD_W-1:0]   wbm_dat_q;

    logic [WORD_W-1:0]   rx_next;
    logic                load_c;

    assign rx_next = {rx_q, sdin_s};

    // Shift register reload: end of dummy phase or after the eighth nibble of a word
    assign load_c = sclk_fall && !ssn_rise && !ssn_fall &&
                    (((state_q == ST_DUMMY) && (bitcnt_q == DUMMY_END)) ||
                     ((state_q == ST_RDATA) && (nib_q == 3'd7)));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            rx_q        <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            tx_q        <= '0;
            nib_q       <= '0;
            rbuf_q      <= '0;
            req_q       <= '0;
            req_vld_q   <= 1'b0;
            sdout_q     <= '0;
            sdout_oen_q <= 1'b1;
            inst_trg_q  <= 1'b0;
            addr_trg_q  <= 1'b0;
            wbm_cyc_q   <= 1'b0;
            wbm_adr_q   <= '0;
            wbm_we_q    <= 1'b0;
            wbm_dat_q   <= '0;
        end else begin
            inst_trg_q <= 1'b0;
            addr_trg_q <= 1'b0;

            // Single outstanding Wishbone cycle; a posted request waits for the bus
            if (wbm_cyc_q) begin
                if (wbm_ack_i || wbm_err_i) begin
                    wbm_cyc_q <= 1'b0;
                    if (!wbm_we_q) begin
                        rbuf_q <= wbm_err_i ? 32'hFFFF_FFFF : wbm_dat_i;
                    end
                end
            end else if (req_vld_q) begin
                wbm_cyc_q <= 1'b1;
                wbm_adr_q <= req_q.adr;
                wbm_we_q  <= req_q.we;
                wbm_dat_q <= req_q.dat;
                req_vld_q <= 1'b0;
            end

            if (ssn_rise) begin
                state_q     <= ST_IDLE;
                bitcnt_q    <= '0;
                sdout_q     <= '0;
                sdout_oen_q <= 1'b1;
            end else if (ssn_fall) begin
                state_q     <= ST_CMD;
                bitcnt_q    <= '0;
                sdout_q     <= '0;
                sdout_oen_q <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE, ST_WAIT: begin
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            rx_q <= rx_next[27:0];
                            if (bitcnt_q == CMD_LAST) begin
                                cmd_q      <= rx_next[7:0];
                                inst_trg_q <= 1'b1;
                                state_q    <= ST_ADDR;
                                bitcnt_q   <= '0;
                            end else begin
                                bitcnt_q <= bitcnt_q + NIB_STEP;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            rx_q <= rx_next[27:0];
                            if (bitcnt_q == WORD_LAST) begin
                                addr_q     <= word_align(rx_next);
                                addr_trg_q <= 1'b1;
                                bitcnt_q   <= '0;
                                if (!wbm_cyc_q && !req_vld_q) begin
                                    wbm_adr_q <= word_align(rx_next);
                                end
                                if (cmd_q == CMD_WR) begin
                                    state_q <= ST_WDATA;
                                end else if (cmd_q == CMD_RD) begin
                                    state_q    <= ST_DUMMY;
                                    req_q.we   <= 1'b0;
                                    req_q.adr  <= word_align(rx_next);
                                    req_q.dat  <= '0;
                                    req_vld_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_WAIT;
                                end
                            end else begin
                                bitcnt_q <= bitcnt_q + NIB_STEP;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (sclk_rise) begin
                            bitcnt_q <= bitcnt_q + NIB_STEP;
                            // Turn the pads around during the high half of the last dummy cycle
                            if (bitcnt_q == DUMMY_LAST) begin
                                sdout_oen_q <= 1'b0;
                            end
                        end else if (load_c) begin
                            state_q  <= ST_RDATA;
                            bitcnt_q <= '0;
                        end
                    end
                    ST_WDATA: begin
                        if (sclk_rise) begin
                            rx_q <= rx_next[27:0];
                            if (bitcnt_q == WORD_LAST) begin
                                req_q.we  <= 1'b1;
                                req_q.adr <= addr_q;
                                req_q.dat <= rx_next;
                                req_vld_q <= 1'b1;
                                addr_q    <= addr_q + 32'd4;
                                bitcnt_q  <= '0;
                            end else begin
                                bitcnt_q <= bitcnt_q + NIB_STEP;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (sclk_rise) begin
                            bitcnt_q <= (bitcnt_q == WORD_LAST) ? '0 : bitcnt_q + NIB_STEP;
                        end else if (sclk_fall && !load_c) begin
                            sdout_q <= tx_q[27:24];
                            tx_q    <= {tx_q[23:0], 4'h0};
                            nib_q   <= nib_q + 3'd1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase

                // Present the next word and prefetch the one after it
                if (load_c) begin
                    tx_q        <= rbuf_q[27:0];
                    sdout_q     <= rbuf_q[31:28];
                    sdout_oen_q <= 1'b0;
                    nib_q       <= '0;
                    addr_q      <= addr_q + 32'd4;
                    req_q.we    <= 1'b0;
                    req_q.adr   <= addr_q + 32'd4;
                    req_q.dat   <= '0;
                    req_vld_q   <= 1'b1;
                end
            end
        end
    end

    assign sdout        = sdout_q;
    assign sdout_oen    = sdout_oen_q;
    assign spi_if_st    = state_q;
    assign sck_toggle   = sclk_rise;
    assign bitcnt       = bitcnt_q;
    assign inst_trg     = inst_trg_q;
    assign addr_trg     = addr_trg_q;
    assign spi_st_trans = ssn_act;
    assign spi_trig     = ssn_fall;
    assign wbm_cyc_o    = wbm_cyc_q;
    assign wbm_stb_o    = wbm_cyc_q;
    assign wbm_adr_o    = wbm_adr_q;
    assign wbm_we_o     = wbm_we_q;
    assign wbm_dat_o    = wbm_dat_q;
    assign wbm_sel_o    = 4'hF;

endmodule

// File: tb/tb_qspis_top.sv
// Bench for qspis_top: QSPI master tasks, Wishbone slave memory model, word-level reference.
`timescale 1ns/1ps
module tb_qspis_top;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        sclk    = 1'b0;
    logic        ssn     = 1'b1;
    logic [3:0]  sdin    = 4'h0;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;

    logic [3:0]  sdout;
    logic        sdout_oen;
    logic [2:0]  spi_if_st;
    logic        sck_toggle;
    logic [5:0]  bitcnt;
    logic        inst_trg, addr_trg, spi_st_trans, spi_trig;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;

    qspis_top dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .sclk(sclk), .ssn(ssn), .sdin(sdin),
        .sdout(sdout), .sdout_oen(sdout_oen), .spi_if_st(spi_if_st),
        .sck_toggle(sck_toggle), .bitcnt(bitcnt), .inst_trg(inst_trg),
        .addr_trg(addr_trg), .spi_st_trans(spi_st_trans), .spi_trig(spi_trig),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_adr_o(wbm_adr_o),
        .wbm_we_o(wbm_we_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    always #5 sys_clk = ~sys_clk;

    localparam int HALF = 8;   // sys_clk cycles per sclk half period

    int total = 0;
    int bad   = 0;

    // Wishbone slave: memory, transaction logs, random latency, optional error replies
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];
    logic [31:0] rd_adr_q[$];
    int          wb_cycles = 0;
    bit          err_mode  = 1'b0;
    int          lat       = 0;
    bit          in_cyc    = 1'b0;
    logic [31:0] start_adr;

    always @(negedge sys_clk) begin
        if (wbm_ack_i || wbm_err_i) begin
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
        end else if (wbm_cyc_o) begin
            if (!in_cyc) begin
                in_cyc    = 1'b1;
                start_adr = wbm_adr_o;
            end
            if (lat > 0) begin
                lat--;
            end else begin
                wb_cycles++;
                total++;
                if (wbm_stb_o !== 1'b1 || wbm_sel_o !== 4'hF || wbm_adr_o !== start_adr) begin
                    bad++;
                    $display("FAIL wb_handshake: stb=%b sel=%h adr=%h, required stb=1 sel=f adr=%h",
                             wbm_stb_o, wbm_sel_o, wbm_adr_o, start_adr);
                end
                if (wbm_we_o) begin
                    wr_adr_q.push_back(wbm_adr_o);
                    wr_dat_q.push_back(wbm_dat_o);
                    wbm_ack_i = 1'b1;
                end else begin
                    rd_adr_q.push_back(wbm_adr_o);
                    if (err_mode) begin
                        wbm_dat_i = $urandom;
                        wbm_err_i = 1'b1;
                    end else begin
                        wbm_dat_i = mem.exists(wbm_adr_o) ? mem[wbm_adr_o] : 32'h0;
                        wbm_ack_i = 1'b1;
                    end
                end
                in_cyc = 1'b0;
                lat    = $urandom_range(0, 3);
            end
        end else begin
            in_cyc = 1'b0;
        end
    end

    // Pulse counters and width monitor
    int   n_inst = 0, n_addr = 0, n_trig = 0, n_wide = 0;
    logic inst_p = 1'b0, addr_p = 1'b0, trig_p = 1'b0, tog_p = 1'b0;
    always @(negedge sys_clk) begin
        if (inst_trg) n_inst++;
        if (addr_trg) n_addr++;
        if (spi_trig) n_trig++;
        if ((inst_trg && inst_p) || (addr_trg && addr_p) ||
            (spi_trig && trig_p) || (sck_toggle && tog_p)) n_wide++;
        inst_p = inst_trg;
        addr_p = addr_trg;
        trig_p = spi_trig;
        tog_p  = sck_toggle;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- QSPI master helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic nib(input logic [3:0] o, output logic [3:0] i, output logic oe);
        sdin = o;
        tick(HALF);
        i  = sdout;
        oe = sdout_oen;
        sclk = 1'b1;
        tick(HALF);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] i;
        logic       oe;
        nib(b[7:4], i, oe);
        nib(b[3:0], i, oe);
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [3:0] i;
        logic       oe;
        for (int k = 7; k >= 0; k--) nib(w[k*4 +: 4], i, oe);
    endtask

    task automatic cs_low();
        ssn = 1'b0;
        tick(6);
    endtask

    task automatic cs_high();
        tick(HALF);
        ssn = 1'b1;
        tick(HALF);
    endtask

    logic [31:0] wbuf [4];

    task automatic do_write(input logic [31:0] a, input int n, output logic [31:0] adr_seen);
        cs_low();
        send_byte(8'h02);
        send_word(a);
        adr_seen = wbm_adr_o;
        for (int k = 0; k < n; k++) send_word(wbuf[k]);
        cs_high();
    endtask

    task automatic wait_wr(input int n);
        for (int c = 0; c < 400 && wr_adr_q.size() < n; c++) tick(1);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] got,
                           output logic [3:0] dummy_oe, output logic data_oe_any);
        logic [3:0] i;
        logic       oe;
        cs_low();
        send_byte(8'h0B);
        send_word(a);
        for (int k = 0; k < 4; k++) begin
            nib(4'h0, i, oe);
            dummy_oe[k] = oe;
        end
        got = '0;
        data_oe_any = 1'b0;
        for (int k = 0; k < 8; k++) begin
            nib(4'h0, i, oe);
            got = {got[27:0], i};
            data_oe_any = data_oe_any | oe;
        end
        cs_high();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [25:0] got;
        got = {spi_if_st, sdout_oen, sdout, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
               bitcnt, spi_st_trans, spi_trig, inst_trg, addr_trg, sck_toggle};
        total++;
        if (got !== {3'd0, 1'b1, 4'h0, 3'b000, 4'hF, 6'd0, 5'b0}) begin
            bad++;
            $display("FAIL reset_ctrl: got %h required %h", got,
                     {3'd0, 1'b1, 4'h0, 3'b000, 4'hF, 6'd0, 5'b0});
        end
        total++;
        if ({wbm_adr_o, wbm_dat_o} !== 64'h0) begin
            bad++;
            $display("FAIL reset_bus: adr=%h dat=%h required 0", wbm_adr_o, wbm_dat_o);
        end
    endtask

    task automatic test_write_single();
        logic [3:0]  i;
        logic        oe;
        int          i0, a0, t0;
        i0 = n_inst; a0 = n_addr; t0 = n_trig;
        wr_adr_q.delete(); wr_dat_q.delete();
        cs_low();
        total++;
        if (spi_st_trans !== 1'b1 || spi_if_st !== 3'd1) begin
            bad++;
            $display("FAIL ws_cs: trans=%b st=%0d required 1/1", spi_st_trans, spi_if_st);
        end
        nib(4'h0, i, oe);
        total++;
        if (bitcnt !== 6'd4) begin
            bad++;
            $display("FAIL ws_bitcnt: got %0d required 4", bitcnt);
        end
        nib(4'h2, i, oe);
        total++;
        if (spi_if_st !== 3'd2 || bitcnt !== 6'd0) begin
            bad++;
            $display("FAIL ws_cmd_done: st=%0d bitcnt=%0d required 2/0", spi_if_st, bitcnt);
        end
        send_word(32'h0000_0010);
        total++;
        if (spi_if_st !== 3'd4 || wbm_adr_o !== 32'h10) begin
            bad++;
            $display("FAIL ws_addr: st=%0d adr=%h required 4/00000010", spi_if_st, wbm_adr_o);
        end
        send_word(32'h1234_5678);
        cs_high();
        wait_wr(1);
        tick(20);
        total++;
        if (wr_adr_q.size() !== 1) begin
            bad++;
            $display("FAIL ws_count: got %0d writes required 1", wr_adr_q.size());
        end else begin
            total++;
            if (wr_adr_q[0] !== 32'h10 || wr_dat_q[0] !== 32'h1234_5678) begin
                bad++;
                $display("FAIL ws_data: adr=%h dat=%h required 00000010/12345678",
                         wr_adr_q[0], wr_dat_q[0]);
            end
        end
        total++;
        if (n_inst - i0 !== 1 || n_addr - a0 !== 1 || n_trig - t0 !== 1) begin
            bad++;
            $display("FAIL ws_pulses: inst=%0d addr=%0d trig=%0d required 1/1/1",
                     n_inst - i0, n_addr - a0, n_trig - t0);
        end
        total++;
        if (spi_if_st !== 3'd0 || spi_st_trans !== 1'b0) begin
            bad++;
            $display("FAIL ws_idle: st=%0d trans=%b required 0/0", spi_if_st, spi_st_trans);
        end
    endtask

    task automatic check_writes(input string nm, input logic [31:0] a, input int n);
        logic [31:0] base;
        base = {a[31:2], 2'b00};
        total++;
        if (wr_adr_q.size() !== n) begin
            bad++;
            $display("FAIL %s_count: got %0d writes required %0d", nm, wr_adr_q.size(), n);
            return;
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if (wr_adr_q[k] !== base + 32'(4 * k) || wr_dat_q[k] !== wbuf[k]) begin
                bad++;
                $display("FAIL %s_word%0d: adr=%h dat=%h required %h/%h", nm, k,
                         wr_adr_q[k], wr_dat_q[k], base + 32'(4 * k), wbuf[k]);
            end
        end
    endtask

    task automatic test_write_burst();
        logic [31:0] seen;
        wr_adr_q.delete(); wr_dat_q.delete();
        wbuf[0] = 32'hA5A5_A5A5;
        wbuf[1] = 32'h5A5A_5A5A;
        do_write(32'h20, 2, seen);
        wait_wr(2);
        tick(20);
        check_writes("burst", 32'h20, 2);
    endtask

    task automatic test_random_write();
        logic [31:0] a, seen;
        int          n;
        for (int r = 0; r < 4; r++) begin
            wr_adr_q.delete(); wr_dat_q.delete();
            a = $urandom;
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) wbuf[k] = $urandom;
            do_write(a, n, seen);
            total++;
            if (seen !== {a[31:2], 2'b00}) begin
                bad++;
                $display("FAIL rw_adr_load: got %h required %h", seen, {a[31:2], 2'b00});
            end
            wait_wr(n);
            tick(20);
            check_writes("rand_wr", a, n);
        end
    endtask

    task automatic test_read();
        logic [31:0] got;
        logic [3:0]  doe;
        logic        oe_any;
        rd_adr_q.delete();
        mem[32'h40] = 32'hDEAD_BEEF;
        mem[32'h44] = $urandom;
        do_read(32'h40, got, doe, oe_any);
        total++;
        if (got !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL rd_data: got %h required deadbeef", got);
        end
        total++;
        if (doe !== 4'hF || oe_any !== 1'b0) begin
            bad++;
            $display("FAIL rd_oen: dummy_oen=%b data_oen_any=%b required 1111/0", doe, oe_any);
        end
        total++;
        if (rd_adr_q.size() < 2 || rd_adr_q[0] !== 32'h40 || rd_adr_q[1] !== 32'h44) begin
            bad++;
            $display("FAIL rd_prefetch: n=%0d first=%h second=%h required 00000040/00000044",
                     rd_adr_q.size(), rd_adr_q.size() > 0 ? rd_adr_q[0] : 32'hx,
                     rd_adr_q.size() > 1 ? rd_adr_q[1] : 32'hx);
        end
        total++;
        if (sdout_oen !== 1'b1 || sdout !== 4'h0 || spi_if_st !== 3'd0) begin
            bad++;
            $display("FAIL rd_after: oen=%b sdout=%h st=%0d required 1/0/0", sdout_oen, sdout, spi_if_st);
        end
    endtask

    task automatic test_read_err();
        logic [31:0] got;
        logic [3:0]  doe;
        logic        oe_any;
        mem[32'h80] = 32'h0123_4567;
        err_mode = 1'b1;
        do_read(32'h80, got, doe, oe_any);
        err_mode = 1'b0;
        tick(10);
        total++;
        if (got !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL rd_err: got %h required ffffffff", got);
        end
    endtask

    task automatic test_random_read();
        logic [31:0] a, exp_w, got;
        logic [3:0]  doe;
        logic        oe_any;
        for (int r = 0; r < 3; r++) begin
            a = $urandom;
            exp_w = $urandom;
            mem[{a[31:2], 2'b00}] = exp_w;
            do_read(a, got, doe, oe_any);
            tick(10);
            total++;
            if (got !== exp_w || oe_any !== 1'b0) begin
                bad++;
                $display("FAIL rand_rd: adr=%h got %h oen_any=%b required %h/0", a, got, oe_any, exp_w);
            end
        end
    endtask

    task automatic test_unknown_cmd();
        int c0;
        c0 = wb_cycles;
        cs_low();
        send_byte(8'h55);
        send_word($urandom);
        total++;
        if (spi_if_st !== 3'd6) begin
            bad++;
            $display("FAIL unk_wait: st=%0d required 6", spi_if_st);
        end
        send_byte(8'($urandom));
        total++;
        if (spi_if_st !== 3'd6 || bitcnt !== 6'd0) begin
            bad++;
            $display("FAIL unk_hold: st=%0d bitcnt=%0d required 6/0", spi_if_st, bitcnt);
        end
        cs_high();
        tick(20);
        total++;
        if (spi_if_st !== 3'd0 || wb_cycles !== c0) begin
            bad++;
            $display("FAIL unk_end: st=%0d wb_cycles=%0d required 0/%0d", spi_if_st, wb_cycles, c0);
        end
    endtask

    task automatic test_partial_write();
        logic [3:0]  i;
        logic        oe;
        logic [31:0] seen;
        wr_adr_q.delete(); wr_dat_q.delete();
        cs_low();
        send_byte(8'h02);
        send_word(32'h100);
        for (int k = 0; k < 3; k++) nib(4'($urandom), i, oe);
        cs_high();
        tick(60);
        total++;
        if (wr_adr_q.size() !== 0 || spi_if_st !== 3'd0 || sdout_oen !== 1'b1) begin
            bad++;
            $display("FAIL partial: writes=%0d st=%0d oen=%b required 0/0/1",
                     wr_adr_q.size(), spi_if_st, sdout_oen);
        end
        wbuf[0] = 32'hC0FF_EE11;
        do_write(32'h104, 1, seen);
        wait_wr(1);
        tick(20);
        check_writes("after_partial", 32'h104, 1);
    endtask

    task automatic test_async_reset();
        logic [25:0] got;
        cs_low();
        send_byte(8'h02);
        sdin = 4'h7;
        sclk = 1'b1;
        tick(2);
        @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        got = {spi_if_st, sdout_oen, sdout, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
               bitcnt, spi_st_trans, spi_trig, inst_trg, addr_trg, sck_toggle};
        total++;
        if (got !== {3'd0, 1'b1, 4'h0, 3'b000, 4'hF, 6'd0, 5'b0} ||
            {wbm_adr_o, wbm_dat_o} !== 64'h0) begin
            bad++;
            $display("FAIL async_rst: got %h adr=%h dat=%h required %h/0/0", got, wbm_adr_o,
                     wbm_dat_o, {3'd0, 1'b1, 4'h0, 3'b000, 4'hF, 6'd0, 5'b0});
        end
        sclk = 1'b0;
        ssn  = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(10);
        total++;
        if (spi_if_st !== 3'd0 || spi_st_trans !== 1'b0) begin
            bad++;
            $display("FAIL async_rst_release: st=%0d trans=%b required 0/0", spi_if_st, spi_st_trans);
        end
    endtask

    task automatic test_pulse_width();
        total++;
        if (n_wide !== 0) begin
            bad++;
            $display("FAIL pulse_width: %0d multi-cycle pulses required 0", n_wide);
        end
    endtask

    initial begin
        tick(5);
        test_reset();
        rst_n = 1'b1;
        tick(5);
        test_write_single();
        test_write_burst();
        test_random_write();
        test_read();
        test_read_err();
        test_random_read();
        test_unknown_cmd();
        test_partial_write();
        test_async_reset();
        test_pulse_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
